// File: rtl/mopshub_test_sequencer_if.sv
// Request/response signals between the MOPSHUB test sequencer and its host,
// data generator and mopshub_top test strobes.
interface mopshub_test_sequencer_if #(
   parameter int N_BUSES = 16
);
   localparam int SEL_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;

   logic               start;
   logic [3:0]         mode_mask;
   logic [N_BUSES-1:0] bus_en;
   logic               end_power_init;
   logic               sign_on;
   logic               test_rx_end;
   logic               test_tx_end;
   logic               costum_msg_end;
   logic               osc_auto_trim;
   logic               test_rx;
   logic               test_tx;
   logic               test_advanced;
   logic               endwait_all;
   logic [SEL_W-1:0]   bus_sel;
   logic               busy;
   logic               done;
   logic [N_BUSES-1:0] pass_mask;
   logic [N_BUSES-1:0] timeout_mask;

   modport master (
      output start, mode_mask, bus_en, end_power_init, sign_on,
             test_rx_end, test_tx_end, costum_msg_end,
      input  osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
             bus_sel, busy, done, pass_mask, timeout_mask
   );

   modport slave (
      input  start, mode_mask, bus_en, end_power_init, sign_on,
             test_rx_end, test_tx_end, costum_msg_end,
      output osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
             bus_sel, busy, done, pass_mask, timeout_mask
   );
endinterface

// File: rtl/mopshub_test_sequencer.sv
// Sequences trim, sign-on, RX, endwait, settle, TX and custom-message tests
// over every enabled CAN bus, supervising each wait with a timeout.
module mopshub_test_sequencer #(
   parameter int N_BUSES        = 16,
   parameter int SETTLE_CYCLES  = 120,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 16
) (
   input logic clk,
   input logic rst,
   mopshub_test_sequencer_if.slave bus
);
   localparam int SEL_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;
   localparam int IDX_W = SEL_W + 1;
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [3:0] {
      IDLE, TRIM, SIGNON, SEL, RX, ENDWAIT, SETTLE, TX, ADV, NEXT, FINISH
   } state_t;

   state_t             state, state_next;
   state_t             nxt_tx, nxt_settle, nxt_endwait, nxt_start;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         mode_q;
   logic [N_BUSES-1:0] bus_en_q;
   logic [IDX_W-1:0]   idx;
   logic               found;
   logic [SEL_W-1:0]   found_idx;
   logic               accept, load_sel, set_pass, set_to_bus, set_to_all;
   logic               is_wait, timed_out;

   // Lowest enabled bus at or above the scan index; descending loop lets the lowest win.
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int i = N_BUSES - 1; i >= 0; i--) begin
         if (bus_en_q[i] && (IDX_W'(i) >= idx)) begin
            found     = 1'b1;
            found_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      load_sel    = 1'b0;
      set_pass    = 1'b0;
      set_to_bus  = 1'b0;
      set_to_all  = 1'b0;
      timed_out   = (cnt == TO_LAST);
      is_wait     = state inside {TRIM, SIGNON, RX, SETTLE, TX, ADV};
      nxt_tx      = mode_q[2] ? ADV : NEXT;
      nxt_settle  = mode_q[1] ? TX : nxt_tx;
      nxt_endwait = (mode_q[1] && (SETTLE_CYCLES > 0)) ? SETTLE : nxt_settle;
      nxt_start   = bus.mode_mask[0] ? TRIM : SIGNON;
      // End pulses are tested before timeouts so a coincident end counts as success.
      case (state)
         IDLE, FINISH: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = nxt_start;
            end else begin
               state_next = IDLE;
            end
         end
         TRIM: begin
            if (bus.end_power_init) state_next = SIGNON;
            else if (timed_out) begin
               set_to_all = 1'b1;
               state_next = FINISH;
            end
         end
         SIGNON: begin
            if (bus.sign_on) state_next = SEL;
            else if (timed_out) begin
               set_to_all = 1'b1;
               state_next = FINISH;
            end
         end
         SEL: begin
            if (found) begin
               load_sel   = 1'b1;
               state_next = mode_q[0] ? RX : ENDWAIT;
            end else begin
               state_next = FINISH;
            end
         end
         RX: begin
            if (bus.test_rx_end) state_next = ENDWAIT;
            else if (timed_out) begin
               set_to_bus = 1'b1;
               state_next = SEL;
            end
         end
         ENDWAIT: state_next = nxt_endwait;
         SETTLE:  if (cnt == SETTLE_LAST) state_next = nxt_settle;
         TX: begin
            if (bus.test_tx_end) state_next = nxt_tx;
            else if (timed_out) begin
               set_to_bus = 1'b1;
               state_next = SEL;
            end
         end
         ADV: begin
            if (bus.costum_msg_end) state_next = NEXT;
            else if (timed_out) begin
               set_to_bus = 1'b1;
               state_next = SEL;
            end
         end
         NEXT: begin
            set_pass   = 1'b1;
            state_next = SEL;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so request levels rise on state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cnt               <= '0;
         mode_q            <= '0;
         bus_en_q          <= '0;
         idx               <= '0;
         bus.bus_sel       <= '0;
         bus.pass_mask     <= '0;
         bus.timeout_mask  <= '0;
         bus.osc_auto_trim <= 1'b0;
         bus.test_rx       <= 1'b0;
         bus.test_tx       <= 1'b0;
         bus.test_advanced <= 1'b0;
         bus.endwait_all   <= 1'b0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= (is_wait && (state_next == state)) ? cnt + 1'b1 : '0;
         if (accept) begin
            mode_q           <= bus.mode_mask[3:1];
            bus_en_q         <= bus.bus_en;
            idx              <= '0;
            bus.pass_mask    <= '0;
            bus.timeout_mask <= '0;
         end
         if (load_sel) begin
            bus.bus_sel <= found_idx;
            idx         <= {1'b0, found_idx};
         end
         if (set_pass || set_to_bus) idx <= idx + 1'b1;
         if (set_pass)   bus.pass_mask[bus.bus_sel]    <= 1'b1;
         if (set_to_bus) bus.timeout_mask[bus.bus_sel] <= 1'b1;
         if (set_to_all) bus.timeout_mask              <= bus_en_q;
         bus.osc_auto_trim <= (state_next == TRIM);
         bus.test_rx       <= (state_next == RX);
         bus.test_tx       <= (state_next == TX);
         bus.test_advanced <= (state_next == ADV);
         bus.endwait_all   <= (state_next == ENDWAIT);
         bus.busy          <= !(state_next inside {IDLE, FINISH});
         bus.done          <= (state_next == FINISH);
      end
   end
endmodule
